// File: rtl/temp_sample_sched.sv
// temp_sample_sched: periodic temperature sample sequencer.
// Requests a 10-bit sample over a req/ack handshake, converts it to four BCD
// digits with a one-iteration-per-cycle double-dabble engine, and generates
// the digit-scan strobe/position for a multiplexed 7-segment display.
// Optional feature: define TEMP_ALARM_EN to build the over-temperature alarm
// comparator; without it, alarm is tied low and alarm_thresh is ignored.
module temp_sample_sched #(
   parameter int SAMPLE_PERIOD = 1000,
   parameter int SCAN_DIV      = 250,
   parameter int TIMEOUT       = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sensor_ack,
   input  logic [9:0]  sensor_data,
   input  logic [9:0]  alarm_thresh,
   output logic        sensor_req,
   output logic [15:0] bcd_digits,
   output logic        bcd_valid,
   output logic        sensor_err,
   output logic        scan_tick,
   output logic [1:0]  digit_pos,
   output logic        alarm
);

   localparam int PW = $clog2(SAMPLE_PERIOD);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, CONV, UPDATE} state_t;

   state_t          state;
   logic [PW-1:0]   period_cnt;
   logic [SW-1:0]   scan_cnt;
   logic [TW-1:0]   wait_cnt;
   logic [3:0]      iter_cnt;
   logic [9:0]      bin_shift;
   logic [15:0]     bcd_scratch;
   logic [15:0]     bcd_adj;
   logic            period_expired;

   assign period_expired = (period_cnt == '0);

   // Free-running sample period counter; expiry only matters when the FSM is idle.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its inputs from before the edge, regardless of statement order.
      if (reset) begin
         period_cnt <= PW'(SAMPLE_PERIOD - 1);
      end else if (period_expired) begin
         period_cnt <= PW'(SAMPLE_PERIOD - 1);
      end else begin
         period_cnt <= period_cnt - 1'b1;
      end
   end

   // Digit-scan divider: one-cycle tick every SCAN_DIV cycles, position wraps 3->0.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt  <= SW'(SCAN_DIV - 1);
         scan_tick <= 1'b0;
         digit_pos <= 2'd0;
      end else if (scan_cnt == '0) begin
         scan_cnt  <= SW'(SCAN_DIV - 1);
         scan_tick <= 1'b1;
         digit_pos <= digit_pos + 2'd1;
      end else begin
         scan_cnt  <= scan_cnt - 1'b1;
         scan_tick <= 1'b0;
      end
   end

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
   always_comb begin
      // NOTE: every bit of bcd_adj is written on every pass, so no latch forms.
      for (int i = 0; i < 4; i++) begin
         bcd_adj[4*i +: 4] = (bcd_scratch[4*i +: 4] >= 4'd5) ?
                             bcd_scratch[4*i +: 4] + 4'd3 : bcd_scratch[4*i +: 4];
      end
   end

   // Sequencing FSM: request, capture, convert, publish.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         sensor_req  <= 1'b0;
         bcd_digits  <= 16'h0000;
         bcd_valid   <= 1'b0;
         sensor_err  <= 1'b0;
         wait_cnt    <= '0;
         iter_cnt    <= 4'd0;
         bin_shift   <= 10'd0;
         bcd_scratch <= 16'h0000;
      end else begin
         bcd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (period_expired) begin
                  state      <= REQ;
                  sensor_req <= 1'b1;
                  wait_cnt   <= '0;
               end
            end
            REQ: begin
               if (sensor_ack) begin
                  bin_shift   <= sensor_data;
                  bcd_scratch <= 16'h0000;
                  iter_cnt    <= 4'd0;
                  sensor_req  <= 1'b0;
                  state       <= CONV;
               end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                  sensor_req <= 1'b0;
                  sensor_err <= 1'b1;
                  state      <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            CONV: begin
               bcd_scratch <= {bcd_adj[14:0], bin_shift[9]};
               bin_shift   <= {bin_shift[8:0], 1'b0};
               iter_cnt    <= iter_cnt + 4'd1;
               if (iter_cnt == 4'd9) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               bcd_digits <= bcd_scratch;
               bcd_valid  <= 1'b1;
               sensor_err <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TEMP_ALARM_EN
   logic [9:0] sample_value;

   // Alarm compares the captured sample against the threshold at publish time.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_value <= 10'd0;
         alarm        <= 1'b0;
      end else begin
         if (state == REQ && sensor_ack) begin
            sample_value <= sensor_data;
         end
         if (state == UPDATE) begin
            alarm <= (sample_value >= alarm_thresh);
         end
      end
   end
`else
   logic unused_alarm_thresh;

   assign unused_alarm_thresh = ^alarm_thresh;
   assign alarm               = 1'b0;
`endif

endmodule

// File: tb/tb_temp_sample_sched.sv
// tb_temp_sample_sched: directed, table-driven bench for temp_sample_sched
// with SAMPLE_PERIOD=20, SCAN_DIV=4, TIMEOUT=8. Honors TEMP_ALARM_EN when
// computing the expected alarm level.
module tb_temp_sample_sched;

   localparam int SP = 20;
   localparam int SD = 4;
   localparam int TO = 8;

`ifdef TEMP_ALARM_EN
   localparam bit ALARM_ON = 1'b1;
`else
   localparam bit ALARM_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        sensor_ack;
   logic [9:0]  sensor_data;
   logic [9:0]  alarm_thresh;
   logic        sensor_req;
   logic [15:0] bcd_digits;
   logic        bcd_valid;
   logic        sensor_err;
   logic        scan_tick;
   logic [1:0]  digit_pos;
   logic        alarm;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [9:0]  data;
      int          delay;
      logic [15:0] digits;
      logic        over;
   } vec_t;

   vec_t vecs [6];

   temp_sample_sched #(
      .SAMPLE_PERIOD(SP),
      .SCAN_DIV     (SD),
      .TIMEOUT      (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sensor_ack  (sensor_ack),
      .sensor_data (sensor_data),
      .alarm_thresh(alarm_thresh),
      .sensor_req  (sensor_req),
      .bcd_digits  (bcd_digits),
      .bcd_valid   (bcd_valid),
      .sensor_err  (sensor_err),
      .scan_tick   (scan_tick),
      .digit_pos   (digit_pos),
      .alarm       (alarm)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!sensor_req && n < 50) begin
         step();
         n++;
      end
      check("req_rise_within_bound", sensor_req, 1);
   endtask

   task automatic do_sample(input logic [9:0] data, input int delay,
                            input logic [15:0] exp_digits, input logic exp_alarm);
      int stray;
      wait_req();
      sensor_data = data;
      sensor_ack  = 1'b0;
      for (int i = 0; i < delay; i++) begin
         step();
      end
      check("req_held_before_ack", sensor_req, 1);
      sensor_ack = 1'b1;
      step();
      sensor_ack  = 1'b0;
      sensor_data = ~data;
      check("req_drop_after_ack", sensor_req, 0);
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bcd_valid) stray++;
      end
      check("no_valid_during_conv", stray, 0);
      step();
      check("valid_at_ack_plus_11", bcd_valid, 1);
      check("bcd_digits", bcd_digits, exp_digits);
      check("alarm_after_update", alarm, exp_alarm);
      check("err_clear_after_update", sensor_err, 0);
      step();
      check("valid_one_cycle", bcd_valid, 0);
   endtask

   initial begin
      int high_cnt;
      int stray;

      vecs[0] = '{10'd987,  2, 16'h0987, 1'b1};
      vecs[1] = '{10'd1023, 0, 16'h1023, 1'b1};
      vecs[2] = '{10'd0,    1, 16'h0000, 1'b0};
      vecs[3] = '{10'd500,  0, 16'h0500, 1'b1};
      vecs[4] = '{10'd499,  3, 16'h0499, 1'b0};
      vecs[5] = '{10'd45,   7, 16'h0045, 1'b0};

      reset        = 1'b1;
      sensor_ack   = 1'b0;
      sensor_data  = 10'd0;
      alarm_thresh = 10'd500;
      step();
      step();
      check("rst_req", sensor_req, 0);
      check("rst_digits", bcd_digits, 16'h0000);
      check("rst_valid", bcd_valid, 0);
      check("rst_err", sensor_err, 0);
      check("rst_tick", scan_tick, 0);
      check("rst_pos", digit_pos, 0);
      check("rst_alarm", alarm, 0);
      reset = 1'b0;

      // First 20 cycles: scan sequence and the first request at cycle 20.
      for (int i = 1; i <= SP; i++) begin
         step();
         check("scan_tick_seq", scan_tick, (i % SD) == 0);
         check("digit_pos_seq", digit_pos, (i / SD) % 4);
         check("first_req_timing", sensor_req, i == SP);
         check("idle_digits_hold", bcd_digits, 16'h0000);
         check("idle_no_valid", bcd_valid, 0);
      end

      for (int v = 0; v < 6; v++) begin
         do_sample(vecs[v].data, vecs[v].delay, vecs[v].digits, vecs[v].over & ALARM_ON);
      end

      // Timeout: request stays up for TIMEOUT cycles with no ack.
      wait_req();
      high_cnt = 0;
      while (sensor_req && high_cnt < 20) begin
         high_cnt++;
         step();
      end
      check("timeout_req_cycles", high_cnt, TO);
      check("timeout_err_set", sensor_err, 1);
      check("timeout_digits_kept", bcd_digits, 16'h0045);
      check("timeout_alarm_kept", alarm, 0);
      check("timeout_no_valid", bcd_valid, 0);

      // Next good sample clears the sticky error.
      do_sample(10'd123, 1, 16'h0123, 1'b0);

      // Alarm set again, then reset mid-conversion must clear everything.
      do_sample(10'd777, 0, 16'h0777, ALARM_ON);
      wait_req();
      sensor_data = 10'd900;
      sensor_ack  = 1'b1;
      step();
      sensor_ack = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      check("midrst_req", sensor_req, 0);
      check("midrst_digits", bcd_digits, 16'h0000);
      check("midrst_valid", bcd_valid, 0);
      check("midrst_err", sensor_err, 0);
      check("midrst_tick", scan_tick, 0);
      check("midrst_pos", digit_pos, 0);
      check("midrst_alarm", alarm, 0);
      reset = 1'b0;
      stray = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (bcd_valid) stray++;
      end
      check("midrst_no_valid", stray, 0);
      check("midrst_digits_after", bcd_digits, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/temp_sample_sched.md
# temp_sample_sched

Sequencing controller that periodically requests a 10-bit temperature sample from the sensor interface, captures it over a req/ack handshake, and converts it to four BCD digits with a sequential double-dabble engine. It also generates the digit-scan strobe and position that drive the multiplexed 7-segment display, so the display path only decodes and drives segments.

## Interface
- SAMPLE_PERIOD, 1000: cycles between sample requests (≥ 16).
- SCAN_DIV, 250: cycles per digit-scan step (≥ 2).
- TIMEOUT, 64: cycles to wait for sensor_ack before aborting (≥ 2).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sensor_ack  in  1  sensor has valid data on sensor_data this cycle.
- sensor_data  in  10  unsigned temperature sample.
- alarm_thresh  in  10  alarm threshold, unsigned (used only with TEMP_ALARM_EN).
- sensor_req  out  1  sample request, level.
- bcd_digits  out  16  {thousands, hundreds, tens, units}, 4 bits each.
- bcd_valid  out  1  one-cycle pulse when bcd_digits updates.
- sensor_err  out  1  sticky timeout flag.
- scan_tick  out  1  one-cycle pulse every SCAN_DIV cycles.
- digit_pos  out  2  current scan position, 0 = units.
- alarm  out  1  over-temperature flag.

## Operation
- FSM states: IDLE, REQ, CONV, UPDATE.
- Period counter runs free. It reloads SAMPLE_PERIOD-1 on reset and on expiry. An expiry in IDLE moves the FSM to REQ. An expiry in any other state is dropped, with no queuing.
- REQ:
  - sensor_req is high for the whole state.
  - On the first cycle sensor_ack=1: capture sensor_data, then go to CONV. sensor_req is low from the next cycle.
  - If sensor_ack is not seen within TIMEOUT cycles of entering REQ: set sensor_err, return to IDLE, and leave bcd_digits unchanged.
- CONV:
  - Runs exactly 10 cycles, one shift-add-3 iteration per cycle, MSB first.
  - 16-bit BCD scratch register; a nibble is corrected (+3) if it is ≥ 5 before each shift.
  - Input range 0–1023, so the thousands digit is 0 or 1. No clamping.
- UPDATE (1 cycle):
  - Load bcd_digits from the scratch register and pulse bcd_valid.
  - Clear sensor_err.
  - Return to IDLE.
- Scan:
  - Independent counter pulses scan_tick every SCAN_DIV cycles.
  - digit_pos increments on each tick and wraps 3→0.
  - Scan runs in every FSM state.
- sensor_ack outside REQ is ignored.

## Timing
- Reset values: sensor_req=0, bcd_digits=16'h0000, bcd_valid=0, sensor_err=0, scan_tick=0, digit_pos=0, alarm=0. FSM=IDLE.
- Reset mid-operation: sensor_req is low and the FSM is in IDLE at the first edge with reset high. The scratch register and any in-flight capture are discarded.
- First sensor_req rises SAMPLE_PERIOD cycles after the last reset cycle.
- First scan_tick occurs SCAN_DIV cycles after the last reset cycle.
- Latency: if sensor_ack is sampled at edge N, CONV occupies edges N+1…N+10. bcd_digits and bcd_valid update at edge N+11, and bcd_valid is high for exactly that one cycle.
- sensor_ack high in the same cycle that sensor_req first rises is accepted, giving a one-cycle handshake.
- If sensor_ack is first seen in the TIMEOUT-th REQ cycle, the capture is accepted and no timeout is raised.
- All outputs are registered.

## Configuration
- TEMP_ALARM_EN defined:
  - In UPDATE, alarm is registered as (captured value ≥ alarm_thresh).
  - alarm holds until the next UPDATE.
  - A timeout leaves alarm unchanged.
- TEMP_ALARM_EN undefined:
  - alarm is tied to 0 and alarm_thresh is unused.
  - No comparator is synthesised.

## Test plan
Unless stated, the bench uses SAMPLE_PERIOD=20, SCAN_DIV=4, TIMEOUT=8.

- **Reset and first request:** release reset, keep sensor_ack=0. All outputs hold their reset values; sensor_req rises exactly 20 cycles after reset release.
- **Conversion:** ack after 2 REQ cycles with sensor_data=10'd987. sensor_req drops next cycle; bcd_valid pulses once 11 cycles after ack; bcd_digits=16'h0987.
- **Max value:** sensor_data=10'd1023 gives bcd_digits=16'h1023. A following sample of 10'd0 gives 16'h0000.
- **Timeout:** no ack.
  - sensor_req is high for 8 cycles, then low; sensor_err=1; bcd_digits is unchanged.
  - The next successful sample clears sensor_err.
- **Scan and reset mid-operation:**
  - scan_tick pulses every 4 cycles; digit_pos runs 0,1,2,3,0.
  - Assert reset during CONV: no bcd_valid is produced and all outputs return to reset values.
- **Alarm (TEMP_ALARM_EN):** alarm_thresh=500.
  - Sample 10'd500 gives alarm=1; sample 10'd499 gives alarm=0.
  - Built without the macro, alarm stays 0 for both samples.
